rr_mux: RTL

RR_MUX -- requirements
Module: rr_mux

---
 rtl/rr_mux_if.sv | 28 ++
 rtl/rr_mux.sv | 110 +++++++++++
 2 files changed

// File: rtl/rr_mux_if.sv
// Handshake bundle for rr_mux: N input channels and one registered output slot.
// The slave modport is the arbiter's view; master is the driving environment's view.
interface rr_mux_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4
);
  localparam int unsigned SELW = $clog2(N);

  logic [1:0]         mode;
  logic [SELW-1:0]    sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_sel;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/rr_mux.sv
// N-channel arbitrating mux (round-robin / fixed priority / direct select)
// feeding a single-slot registered output with full-throughput handshake.
module rr_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  rr_mux_if.slave  bus
);
  localparam int unsigned SELW        = $clog2(N);
  localparam logic [1:0]  MODE_FIXED  = 2'b01;
  localparam logic [1:0]  MODE_DIRECT = 2'b10;

  logic [SELW-1:0]  ptr_q;
  logic [SELW-1:0]  ptr_nxt;
  logic [SELW-1:0]  grant_idx;
  logic             grant_vld;
  logic [WIDTH-1:0] grant_data;
  logic             accept;
  logic             xfer;
  logic [N-1:0]     in_ready_c;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_sel_q;
  logic             out_valid_q;

  // Grant selection; loops run high-to-low so the first hit in search order wins.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    case (bus.mode)
      MODE_FIXED: begin
        for (int i = int'(N) - 1; i >= 0; i--) begin
          if (bus.in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SELW'(i);
          end
        end
      end
      MODE_DIRECT: begin
        // sel values with no matching channel simply never hit.
        for (int i = 0; i < int'(N); i++) begin
          if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SELW'(i);
          end
        end
      end
      default: begin
        for (int k = int'(N) - 1; k >= 0; k--) begin
          idx = int'(ptr_q) + k;
          if (idx >= int'(N)) idx = idx - int'(N);
          if (bus.in_valid[idx]) begin
            grant_vld = 1'b1;
            grant_idx = SELW'(idx);
          end
        end
      end
    endcase
  end

  // Data path mux for the granted channel.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_idx == SELW'(i)) grant_data = bus.in_data[i*int'(WIDTH) +: WIDTH];
    end
  end

  assign accept  = (!out_valid_q || bus.out_ready) && rst_n;
  assign xfer    = accept && grant_vld;
  assign ptr_nxt = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);

  always_comb begin
    in_ready_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      in_ready_c[i] = xfer && (grant_idx == SELW'(i));
    end
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_data;
      out_sel_q   <= grant_idx;
      ptr_q       <= ptr_nxt;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready_c));

  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus.out_ready) |-> (in_ready_c == '0));

endmodule
